damage_calc: RTL
================

# damage_calc

Per-turn combat damage engine for the battlefield. It is started by `damageSCEN` from the turn sequencer and walks every lane of the lane store. For each lane it computes the damage each front unit takes and the damage that reaches each base. It raises `damageCalcDone` so the sequencer can leave its damage-wait state and apply the results.

## Interface

Parameters:
- `NUM_LANES`, default 8: number of lanes scanned per turn (≥1).
- `ATK_W`, default 6: width of attack and defense values.
- `HP_W`, default 8: width of per-unit damage outputs.
- `BASE_W`, default 12: width of base-damage accumulators.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `damageSCEN` in 1: start strobe from the turn sequencer.
- `lane_addr` out clog2(NUM_LANES): lane being read from the lane store.
- `p1_occ`, `p2_occ` in 1 each: front unit present in `lane_addr` for player 1 / player 2. Combinational read.
- `p1_atk`, `p1_def`, `p2_atk`, `p2_def` in ATK_W each: stats of those front units.
- `dmg_we` out 1: damage write strobe.
- `dmg_addr` out clog2(NUM_LANES): lane being written.
- `dmg_to_p1`, `dmg_to_p2` out HP_W each: damage to each lane's front unit.
- `base_dmg_p1`, `base_dmg_p2` out BASE_W each: accumulated damage to each base this turn.
- `damageCalcDone` out 1: level, calculation complete.

## Operation

FSM states: IDLE, FETCH, COMPUTE, WRITE, DONE.

- **IDLE**
  - On `damageSCEN`=1: clear both base accumulators, set lane counter to 0, go to FETCH.
- **FETCH**
  - Drive `lane_addr` = counter.
  - Register `p1_occ`, `p2_occ`, and all four stat inputs on the exiting edge.
  - Go to COMPUTE.
- **COMPUTE**
  - Registered damage rule: f(a,d) = 1 if a ≤ d, else a−d.
    - f is zero-extended to HP_W.
    - If HP_W < ATK_W, f saturates at 2^HP_W−1.
  - Both units present: `dmg_to_p2` = f(p1_atk, p2_def); `dmg_to_p1` = f(p2_atk, p1_def).
  - Only p1 present: both unit damages are 0; `base_dmg_p2` += p1_atk.
  - Only p2 present: both unit damages are 0; `base_dmg_p1` += p2_atk.
  - Neither present: both unit damages are 0; no accumulation.
  - Accumulators saturate at 2^BASE_W−1 and never wrap.
  - Go to WRITE.
- **WRITE**
  - Drive `dmg_we` = 1 only if both units were present; otherwise `dmg_we` = 0.
  - `dmg_addr` = counter.
  - Last lane (counter = NUM_LANES−1): go to DONE. Otherwise increment counter and go to FETCH.
- **DONE**
  - `damageCalcDone` = 1.
  - Hold until `damageSCEN`=1, then clear the accumulators, set counter to 0, and go to FETCH. `damageCalcDone` falls the same edge.

Boundary rules:
- `damageSCEN` in FETCH, COMPUTE or WRITE is ignored; no restart and no counter disturbance.
- Every lane takes exactly 3 cycles regardless of occupancy, so latency is fixed.
- `base_dmg_*` stay valid and stable from DONE until the next start.
- Reset mid-scan aborts immediately. There is no partial write after reset deassertion.

## Timing

- Reset values:
  - state IDLE
  - `damageCalcDone`=0, `dmg_we`=0
  - `lane_addr`=0, `dmg_addr`=0
  - `dmg_to_p1`=0, `dmg_to_p2`=0
  - `base_dmg_p1`=0, `base_dmg_p2`=0
- Start sampled at edge E0. Lane i is in:
  - FETCH during cycle 1+3i
  - COMPUTE during cycle 2+3i
  - WRITE during cycle 3+3i
- `damageCalcDone` rises at edge E(3·NUM_LANES+1), which is E25 for 8 lanes.
- `dmg_we` is a single-cycle pulse per lane, never back-to-back.
- `dmg_to_*` and `dmg_addr` are stable for the whole WRITE cycle.
- Lane store read is combinational. Inputs must be valid in the FETCH cycle for the current `lane_addr`.
- Restart from DONE yields the same timing relative to the new start edge.

## Test plan

- **Reset and idle:** assert `reset` mid-cycle. Required: all outputs 0 asynchronously. After release, with no `damageSCEN`, the FSM stays in IDLE.
- **Full duel, NUM_LANES=8:** all lanes both occupied, p1_atk=10, p2_def=4, p2_atk=3, p1_def=5. Required:
  - 8 `dmg_we` pulses, at cycles 3, 6, …, 24, with `dmg_addr` 0..7.
  - `dmg_to_p2`=6 and `dmg_to_p1`=1 (minimum-damage rule).
  - `damageCalcDone` rises at E25; base damages are 0.
- **Base hits:** lanes 0–3 p1-only with atk=20; lanes 4–7 p2-only with atk=7. Required: `dmg_we` never asserts; `base_dmg_p2`=80 and `base_dmg_p1`=28 at DONE.
- **Saturation:** BASE_W=6, all lanes p1-only with p1_atk=63. Required: `base_dmg_p2`=63 at DONE, never wrapping.
- **Start while busy, then restart:** pulse `damageSCEN` at cycle 10. Required: ignored, done still at E25. Then start from DONE. Required: done falls the next edge, accumulators clear, and the second done arrives 25 cycles after the restart edge.
- **Reset mid-scan:** assert reset during lane 3 COMPUTE. Required: IDLE with all outputs 0, and no `dmg_we` for lane 3. A subsequent start scans from lane 0.

Source files
------------

// File: rtl/damage_calc.sv
// Per-turn combat damage engine: walks every lane of the lane store, computes
// the damage dealt to front units and the damage that reaches each base.
module damage_calc #(
   parameter int NUM_LANES = 8,
   parameter int ATK_W     = 6,
   parameter int HP_W      = 8,
   parameter int BASE_W    = 12,
   localparam int AW       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              damageSCEN,
   output logic [AW-1:0]     lane_addr,
   input  logic              p1_occ,
   input  logic              p2_occ,
   input  logic [ATK_W-1:0]  p1_atk,
   input  logic [ATK_W-1:0]  p1_def,
   input  logic [ATK_W-1:0]  p2_atk,
   input  logic [ATK_W-1:0]  p2_def,
   output logic              dmg_we,
   output logic [AW-1:0]     dmg_addr,
   output logic [HP_W-1:0]   dmg_to_p1,
   output logic [HP_W-1:0]   dmg_to_p2,
   output logic [BASE_W-1:0] base_dmg_p1,
   output logic [BASE_W-1:0] base_dmg_p2,
   output logic              damageCalcDone
);

   localparam int MW = (ATK_W > HP_W) ? ATK_W : HP_W;
   localparam int SW = ((BASE_W > ATK_W) ? BASE_W : ATK_W) + 1;
   localparam logic [AW-1:0] LAST_LANE = AW'(NUM_LANES - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      COMPUTE = 3'd2,
      WRITE   = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t            state;
   logic              occ1_r;
   logic              occ2_r;
   logic [ATK_W-1:0]  atk1_r;
   logic [ATK_W-1:0]  def1_r;
   logic [ATK_W-1:0]  atk2_r;
   logic [ATK_W-1:0]  def2_r;

   // A hit always lands for at least 1; results wider than HP_W clip to the max.
   function automatic logic [HP_W-1:0] unit_dmg(input logic [ATK_W-1:0] a,
                                                input logic [ATK_W-1:0] d);
      logic [MW-1:0] diff;
      logic [MW-1:0] hp_max;
      diff   = MW'(a) - MW'(d);
      hp_max = MW'({HP_W{1'b1}});
      if (a <= d) begin
         unit_dmg = HP_W'(1'b1);
      end else if (diff > hp_max) begin
         unit_dmg = {HP_W{1'b1}};
      end else begin
         unit_dmg = diff[HP_W-1:0];
      end
   endfunction

   function automatic logic [BASE_W-1:0] sat_add(input logic [BASE_W-1:0] acc,
                                                 input logic [ATK_W-1:0]  inc);
      logic [SW-1:0] sum;
      sum = SW'(acc) + SW'(inc);
      if (sum > SW'({BASE_W{1'b1}})) begin
         sat_add = {BASE_W{1'b1}};
      end else begin
         sat_add = sum[BASE_W-1:0];
      end
   endfunction

   // Lane-scan FSM; lane_addr doubles as the lane counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         lane_addr      <= '0;
         dmg_addr       <= '0;
         dmg_we         <= 1'b0;
         dmg_to_p1      <= '0;
         dmg_to_p2      <= '0;
         base_dmg_p1    <= '0;
         base_dmg_p2    <= '0;
         damageCalcDone <= 1'b0;
         occ1_r         <= 1'b0;
         occ2_r         <= 1'b0;
         atk1_r         <= '0;
         def1_r         <= '0;
         atk2_r         <= '0;
         def2_r         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (damageSCEN) begin
                  base_dmg_p1 <= '0;
                  base_dmg_p2 <= '0;
                  lane_addr   <= '0;
                  state       <= FETCH;
               end else begin
                  state <= IDLE;
               end
            end
            FETCH: begin
               occ1_r <= p1_occ;
               occ2_r <= p2_occ;
               atk1_r <= p1_atk;
               def1_r <= p1_def;
               atk2_r <= p2_atk;
               def2_r <= p2_def;
               state  <= COMPUTE;
            end
            COMPUTE: begin
               dmg_addr <= lane_addr;
               state    <= WRITE;
               case ({occ1_r, occ2_r})
                  2'b11: begin
                     dmg_to_p2 <= unit_dmg(atk1_r, def2_r);
                     dmg_to_p1 <= unit_dmg(atk2_r, def1_r);
                     dmg_we    <= 1'b1;
                  end
                  2'b10: begin
                     dmg_to_p1   <= '0;
                     dmg_to_p2   <= '0;
                     dmg_we      <= 1'b0;
                     base_dmg_p2 <= sat_add(base_dmg_p2, atk1_r);
                  end
                  2'b01: begin
                     dmg_to_p1   <= '0;
                     dmg_to_p2   <= '0;
                     dmg_we      <= 1'b0;
                     base_dmg_p1 <= sat_add(base_dmg_p1, atk2_r);
                  end
                  default: begin
                     dmg_to_p1 <= '0;
                     dmg_to_p2 <= '0;
                     dmg_we    <= 1'b0;
                  end
               endcase
            end
            WRITE: begin
               dmg_we <= 1'b0;
               if (lane_addr == LAST_LANE) begin
                  state <= DONE;
               end else begin
                  lane_addr <= lane_addr + AW'(1);
                  state     <= FETCH;
               end
            end
            DONE: begin
               // Done rises one edge after entry so it lands on E(3*NUM_LANES+1).
               if (damageSCEN) begin
                  damageCalcDone <= 1'b0;
                  base_dmg_p1    <= '0;
                  base_dmg_p2    <= '0;
                  lane_addr      <= '0;
                  state          <= FETCH;
               end else begin
                  damageCalcDone <= 1'b1;
                  state          <= DONE;
               end
            end
            default: begin
               state          <= IDLE;
               dmg_we         <= 1'b0;
               damageCalcDone <= 1'b0;
            end
         endcase
      end
   end

endmodule
